edge_trigger_counter: RTL and testbench

EDGE_TRIGGER_COUNTER -- requirements
Module: edge_trigger_counter

---
 rtl/edge_trig_pkg.sv | 26 ++
 rtl/edge_trigger_counter_if.sv | 33 +++
 rtl/edge_trigger_counter_edge_detect.sv | 43 ++++
 rtl/edge_trigger_counter.sv | 118 +++++++++++
 tb/tb_edge_trigger_counter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edge_trig_pkg.sv
// Shared types for the edge trigger counter: FSM states, edge-mode codes
// and the helper that turns a rise/fall pair into a qualifying edge.
package edge_trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  // The reserved code 2'b11 behaves like MODE_BOTH.
  function automatic logic edge_hit(input logic [1:0] mode,
                                    input logic rise,
                                    input logic fall);
    case (mode)
      MODE_RISE: return rise;
      MODE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/edge_trigger_counter_if.sv
// Control/status bundle of the edge trigger counter.
// arm and disarm are single-cycle strobes sampled on every rdclk edge (no
// handshake: a high level is a request that cycle, and disarm beats arm);
// armed/trig/trig_pulse/count are registered status, valid every cycle.
interface edge_trigger_counter_if #(
  parameter int CH = 8,
  parameter int CW = 16
);
  localparam int SW = $clog2(CH);

  logic          en;
  logic [CH-1:0] din;
  logic [SW-1:0] ch_sel;
  logic [1:0]    mode;
  logic [CW-1:0] threshold;
  logic          arm;
  logic          disarm;
  logic          armed;
  logic          trig;
  logic          trig_pulse;
  logic [CW-1:0] count;

  modport master (
    output en, din, ch_sel, mode, threshold, arm, disarm,
    input  armed, trig, trig_pulse, count
  );

  modport slave (
    input  en, din, ch_sel, mode, threshold, arm, disarm,
    output armed, trig, trig_pulse, count
  );

endinterface

// File: rtl/edge_trigger_counter_edge_detect.sv
// Per-channel edge front end: two-flop synchronizer followed by a history
// register that only advances on enabled samples (or when a capture is armed,
// so the new capture starts from the current level instead of stale history).
module edge_detect #(
  parameter int CH = 8
) (
  input  logic          rdclk,
  input  logic          nreset,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CH-1:0] din_i,
  output logic [CH-1:0] rise_o,
  output logic [CH-1:0] fall_o
);

  logic [CH-1:0] s1_q;
  logic [CH-1:0] s2_q;
  logic [CH-1:0] prev_q;

  // Synchronizer runs every cycle regardless of en.
  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  // History advances on enabled samples and on arm.
  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      prev_q <= '0;
    end else if (en_i || load_i) begin
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;
  assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/edge_trigger_counter.sv
// Edge trigger counter: counts qualifying edges on one latched channel after
// arm and fires a trigger when the count reaches the latched threshold.
module edge_trigger_counter
  import edge_trig_pkg::*;
#(
  parameter int CH = 8,
  parameter int CW = 16
) (
  input  logic                  rdclk,
  input  logic                  nreset,
  edge_trigger_counter_if.slave bus,
  output state_t                dbg_state_o
);

  localparam int SW = $clog2(CH);

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] thr_q;
  logic [SW-1:0] ch_q;
  logic [1:0]    mode_q;
  logic          armed_q;
  logic          trig_q;
  logic          pulse_q;

  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          load;
  logic          qual;
  logic [CW-1:0] count_inc;
  logic [SW-1:0] ch_d;

  // disarm wins over arm, so only a clean arm reloads the edge history.
  assign load      = bus.arm & ~bus.disarm;
  // Out-of-range channel selects fall back to channel 0.
  assign ch_d      = (int'(bus.ch_sel) < CH) ? bus.ch_sel : '0;
  assign qual      = bus.en & edge_hit(mode_q, rise[ch_q], fall[ch_q]);
  assign count_inc = count_q + CW'(1);

  edge_detect #(.CH(CH)) u_edge_detect (
    .rdclk  (rdclk),
    .nreset (nreset),
    .en_i   (bus.en),
    .load_i (load),
    .din_i  (bus.din),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Capture FSM with edge counter, latched config and registered outputs.
  always_ff @(posedge rdclk) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      thr_q   <= '0;
      ch_q    <= '0;
      mode_q  <= '0;
      armed_q <= 1'b0;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (bus.disarm) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        armed_q <= 1'b0;
        trig_q  <= 1'b0;
      end else if (bus.arm) begin
        state_q <= ST_ARMED;
        count_q <= '0;
        thr_q   <= bus.threshold;
        ch_q    <= ch_d;
        mode_q  <= bus.mode;
        armed_q <= 1'b1;
        trig_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_ARMED: begin
            if (thr_q == '0) begin
              // Zero threshold fires on the first armed cycle.
              state_q <= ST_TRIGGERED;
              armed_q <= 1'b0;
              trig_q  <= 1'b1;
              pulse_q <= 1'b1;
            end else if (qual && (count_q != thr_q)) begin
              count_q <= count_inc;
              if (count_inc == thr_q) begin
                state_q <= ST_TRIGGERED;
                armed_q <= 1'b0;
                trig_q  <= 1'b1;
                pulse_q <= 1'b1;
              end
            end
          end
          ST_TRIGGERED: begin
            state_q <= ST_TRIGGERED;
          end
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
            count_q <= '0;
            armed_q <= 1'b0;
            trig_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.armed      = armed_q;
  assign bus.trig       = trig_q;
  assign bus.trig_pulse = pulse_q;
  assign bus.count      = count_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_edge_trigger_counter.sv
// Self-checking bench for edge_trigger_counter: directed scenarios plus a
// randomized run, all compared against a behavioural reference model.
module tb_edge_trigger_counter;
  import edge_trig_pkg::*;

  localparam int CH = 8;
  localparam int CW = 16;
  localparam int SW = $clog2(CH);

  // ---------------- clock / reset ----------------
  logic   rdclk = 1'b0;
  logic   nreset;
  state_t dbg_state;

  always #5 rdclk = ~rdclk;

  edge_trigger_counter_if #(.CH(CH), .CW(CW)) bus ();

  edge_trigger_counter #(.CH(CH), .CW(CW)) dut (
    .rdclk       (rdclk),
    .nreset      (nreset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // The channel value the counter reacts to at edge m is din from edge m-2,
  // forced to zero if a reset edge intervened. m_seen is the level last
  // accepted as "known" (on an enabled sample or at arm).
  logic [CH-1:0] hist[$];
  bit            rst_hist[$];
  int            m_state = 0;  // 0 idle, 1 armed, 2 triggered
  logic [CW-1:0] m_count = '0;
  logic [CW-1:0] m_thr   = '0;
  int            m_ch    = 0;
  logic [1:0]    m_mode  = '0;
  logic [CH-1:0] m_seen  = '0;
  bit            m_pulse = 1'b0;
  logic [CH-1:0] m_vis;
  bit            m_rise, m_fall, m_hit;
  int            m_k;

  always @(posedge rdclk) begin
    m_k   = hist.size();
    m_vis = (m_k >= 2 && !rst_hist[m_k-1]) ? hist[m_k-2] : '0;
    hist.push_back(nreset ? bus.din : '0);
    rst_hist.push_back(!nreset);
    m_pulse = 1'b0;
    if (!nreset) begin
      m_state = 0; m_count = '0; m_thr = '0; m_ch = 0; m_mode = '0; m_seen = '0;
    end else begin
      m_rise = m_vis[m_ch] && !m_seen[m_ch];
      m_fall = !m_vis[m_ch] && m_seen[m_ch];
      m_hit  = bus.en && ((m_mode == 2'b00) ? m_rise :
                          (m_mode == 2'b01) ? m_fall : (m_rise || m_fall));
      if (bus.disarm) begin
        m_state = 0; m_count = '0;
      end else if (bus.arm) begin
        m_state = 1; m_count = '0; m_thr = bus.threshold; m_mode = bus.mode;
        m_ch    = (int'(bus.ch_sel) < CH) ? int'(bus.ch_sel) : 0;
      end else if (m_state == 1) begin
        if (m_thr == '0) begin
          m_state = 2; m_pulse = 1'b1;
        end else if (m_hit) begin
          m_count++;
          if (m_count == m_thr) begin
            m_state = 2; m_pulse = 1'b1;
          end
        end
      end
      if (bus.en || (bus.arm && !bus.disarm)) m_seen = m_vis;
    end
  end

  function automatic logic [CW+2:0] exp_vec();
    return {m_state == 1, m_state == 2, m_pulse, m_count};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rdclk);
    @(negedge rdclk);
  endtask

  task automatic quiet(input int n);
    bus.din = '0; bus.arm = 1'b0; bus.disarm = 1'b0;
    repeat (n) tick();
  endtask

  // Arm, then scramble the config inputs: they must have no further effect.
  task automatic do_arm(input int ch, input logic [1:0] md, input int thr);
    bus.ch_sel = SW'(ch); bus.mode = md; bus.threshold = CW'(thr);
    bus.arm = 1'b1;
    tick();
    bus.arm       = 1'b0;
    bus.ch_sel    = SW'($urandom_range(0, CH-1));
    bus.mode      = 2'($urandom_range(0, 3));
    bus.threshold = CW'($urandom_range(0, 15));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0; bus.arm = 1'b1; bus.din = CH'($urandom());
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== '0 || dbg_state !== ST_IDLE)
        $display("FAIL reset_state c=%0d got armed=%b trig=%b pulse=%b count=%0d state=%0d exp all 0",
                 c, bus.armed, bus.trig, bus.trig_pulse, bus.count, dbg_state);
      else n_pass++;
    end
    bus.arm = 1'b0; nreset = 1'b1;
    tick();
    n_checks++;
    if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
      $display("FAIL reset_release got=%h exp=%h", {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
    else n_pass++;
  endtask

  task automatic test_rise();
    logic [CH-1:0] d;
    bus.en = 1'b1; quiet(4);
    do_arm(3, MODE_RISE, 5);
    n_checks++;
    if (bus.armed !== 1'b1 || bus.count !== '0)
      $display("FAIL rise_armed got armed=%b count=%0d exp armed=1 count=0", bus.armed, bus.count);
    else n_pass++;
    for (int c = 0; c < 24; c++) begin
      d = CH'($urandom());
      d[3] = (c < 20) && ((c % 4) < 2);
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL rise_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
      if (c < 20 && (c % 4) == 2) begin
        n_checks++;
        if (bus.count !== CW'(c / 4 + 1))
          $display("FAIL rise_count c=%0d got=%0d exp=%0d", c, bus.count, c / 4 + 1);
        else n_pass++;
      end
      if (c == 17 || c == 18 || c == 19) begin
        n_checks++;
        if (bus.trig !== (c >= 18) || bus.trig_pulse !== (c == 18))
          $display("FAIL rise_trig c=%0d got trig=%b pulse=%b exp trig=%b pulse=%b",
                   c, bus.trig, bus.trig_pulse, c >= 18, c == 18);
        else n_pass++;
      end
    end
  endtask

  task automatic test_both();
    logic [CH-1:0] d;
    bus.en = 1'b1; quiet(4);
    do_arm(5, MODE_BOTH, 4);
    for (int c = 0; c < 12; c++) begin
      d = CH'($urandom()); d[5] = 1'b0;
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL both_other_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (bus.count !== '0 || bus.armed !== 1'b1)
      $display("FAIL both_other_chan got count=%0d armed=%b exp count=0 armed=1", bus.count, bus.armed);
    else n_pass++;
    for (int c = 0; c < 18; c++) begin
      d = CH'($urandom());
      d[5] = (c < 16) && (((c / 4) % 2) == 0);
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL both_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
      if (c == 10 || c == 14) begin
        n_checks++;
        if (bus.count !== CW'(c == 10 ? 3 : 4) || bus.trig !== (c == 14) || bus.trig_pulse !== (c == 14))
          $display("FAIL both_trig c=%0d got count=%0d trig=%b pulse=%b", c, bus.count, bus.trig, bus.trig_pulse);
        else n_pass++;
      end
    end
  endtask

  task automatic test_en_gating();
    logic [CH-1:0] d;
    bus.en = 1'b1; quiet(4);
    do_arm(0, MODE_RISE, 7);
    for (int c = 0; c < 20; c++) begin
      bus.en = ((c % 4) == 0);
      d = CH'($urandom());
      d[0] = (c == 1) || (c >= 9 && c <= 12);
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL en_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
      if (c == 8 || c == 11 || c == 12 || c == 19) begin
        n_checks++;
        if (bus.count !== CW'(c >= 12 ? 1 : 0))
          $display("FAIL en_count c=%0d got=%0d exp=%0d", c, bus.count, c >= 12 ? 1 : 0);
        else n_pass++;
      end
    end
    d = '0;
    for (int c = 0; c < 40; c++) begin
      bus.en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) d[0] = ~d[0];
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL en_rand_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_thr_zero();
    bus.en = 1'b1; quiet(3);
    bus.en = 1'b0;
    do_arm($urandom_range(0, CH-1), MODE_RISE, 0);
    n_checks++;
    if (bus.armed !== 1'b1 || bus.trig !== 1'b0 || bus.count !== '0)
      $display("FAIL thr0_armed got armed=%b trig=%b count=%0d exp 1 0 0", bus.armed, bus.trig, bus.count);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.trig !== 1'b1 || bus.trig_pulse !== 1'b1 || bus.armed !== 1'b0 || bus.count !== '0)
      $display("FAIL thr0_trig got trig=%b pulse=%b armed=%b count=%0d exp 1 1 0 0",
               bus.trig, bus.trig_pulse, bus.armed, bus.count);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.trig !== 1'b1 || bus.trig_pulse !== 1'b0)
      $display("FAIL thr0_pulse_once got trig=%b pulse=%b exp trig=1 pulse=0", bus.trig, bus.trig_pulse);
    else n_pass++;
    bus.en = 1'b1;
    do_arm(1, MODE_RISE, 5);
    bus.arm = 1'b1; bus.disarm = 1'b1;
    tick();
    bus.arm = 1'b0; bus.disarm = 1'b0;
    n_checks++;
    if (bus.armed !== 1'b0 || bus.trig !== 1'b0 || bus.count !== '0 || dbg_state !== ST_IDLE)
      $display("FAIL arm_disarm got armed=%b trig=%b count=%0d state=%0d exp idle",
               bus.armed, bus.trig, bus.count, dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [CH-1:0] d;
    bus.en = 1'b1; quiet(4);
    do_arm(2, MODE_RISE, 8);
    for (int c = 0; c < 14; c++) begin
      d = CH'($urandom()); d[2] = (c < 12) && ((c % 4) < 2);
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL rstmid_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (bus.count !== CW'(3) || bus.armed !== 1'b1)
      $display("FAIL rstmid_pre got count=%0d armed=%b exp count=3 armed=1", bus.count, bus.armed);
    else n_pass++;
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    n_checks++;
    if (bus.count !== '0 || bus.armed !== 1'b0 || bus.trig !== 1'b0 || bus.trig_pulse !== 1'b0)
      $display("FAIL rstmid_abort got count=%0d armed=%b trig=%b pulse=%b exp all 0",
               bus.count, bus.armed, bus.trig, bus.trig_pulse);
    else n_pass++;
    quiet(4);
    do_arm(2, MODE_RISE, 2);
    for (int c = 0; c < 10; c++) begin
      d = CH'($urandom()); d[2] = (c < 8) && ((c % 4) < 2);
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL rstmid_rearm_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
      if (c == 6) begin
        n_checks++;
        if (bus.count !== CW'(2) || bus.trig !== 1'b1 || bus.trig_pulse !== 1'b1)
          $display("FAIL rstmid_rearm_trig got count=%0d trig=%b pulse=%b exp 2 1 1",
                   bus.count, bus.trig, bus.trig_pulse);
        else n_pass++;
      end
    end
  endtask

  task automatic test_trig_hold();
    logic [CH-1:0] d;
    int bad;
    bus.en = 1'b1; quiet(4);
    do_arm(1, MODE_RISE, 3);
    bad = 0;
    for (int c = 0; c < 52; c++) begin
      d = CH'($urandom()); d[1] = ((c % 4) < 2);
      bus.din = d;
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL hold_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
      if (c >= 10 && (bus.count !== CW'(3) || bus.trig !== 1'b1)) bad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL hold_count got %0d cycles off count=3/trig=1, exp 0 (last count=%0d)", bad, bus.count);
    else n_pass++;
    do_arm(1, MODE_RISE, 3);
    n_checks++;
    if (bus.count !== '0 || bus.armed !== 1'b1 || bus.trig !== 1'b0)
      $display("FAIL hold_rearm got count=%0d armed=%b trig=%b exp 0 1 0", bus.count, bus.armed, bus.trig);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [CH-1:0] d;
    d = bus.din;
    for (int c = 0; c < 500; c++) begin
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) d[$urandom_range(0, CH-1)] ^= 1'b1;
      bus.din       = d;
      bus.arm       = ($urandom_range(0, 15) == 0);
      bus.disarm    = ($urandom_range(0, 39) == 0);
      bus.ch_sel    = SW'($urandom_range(0, CH-1));
      bus.mode      = 2'($urandom_range(0, 3));
      bus.threshold = CW'($urandom_range(0, 4));
      nreset        = ($urandom_range(0, 149) != 0);
      tick();
      n_checks++;
      if ({bus.armed, bus.trig, bus.trig_pulse, bus.count} !== exp_vec())
        $display("FAIL random_model c=%0d got=%h exp=%h", c, {bus.armed, bus.trig, bus.trig_pulse, bus.count}, exp_vec());
      else n_pass++;
    end
    nreset = 1'b1; bus.arm = 1'b0; bus.disarm = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    nreset = 1'b0;
    bus.en = 1'b0; bus.din = '0; bus.ch_sel = '0; bus.mode = '0;
    bus.threshold = '0; bus.arm = 1'b0; bus.disarm = 1'b0;
    test_reset();
    test_rise();
    test_both();
    test_en_gating();
    test_thr_zero();
    test_reset_mid();
    test_trig_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
